jpeg_dqt_pipe: RTL and testbench



---
 rtl/jpeg_dqt_pipe.sv | 253 +++++++++++++++++++++++++
 tb/tb_jpeg_dqt_pipe.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_dqt_pipe.sv
// jpeg_dqt_pipe: JPEG dequantiser and de-zigzag stage.
//
// DQT segment bytes load up to NUM_TABLES quantisation tables (8- or 16-bit
// entries, kept in zigzag order). Each coefficient is multiplied by its table
// entry and its zigzag index is remapped to raster order through a two-stage
// pipeline with valid/accept handshakes on both streams.
//
// Build option: define JPEG_DQT_SAT_EN to saturate the product to the signed
// COEF_W range; without it the low COEF_W bits of the product are output.
//
// Config FSM
//   state   | meaning
//   CFG_HDR | waiting for a table header byte (Pq, Tq); coefficients allowed
//   CFG_HI  | waiting for the high byte of a 16-bit entry
//   CFG_LO  | waiting for the low (or only) byte of an entry; writes the table

module jpeg_dqt_pipe #(
   parameter int  NUM_TABLES = 4,
   parameter int  COEF_W     = 16,
   parameter int  Q_W        = 16,
   parameter int  ID_W       = 32,
   localparam int TID_W      = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                img_start_i,
   input  logic [4*TID_W-1:0]  img_dqt_table_i,
   input  logic                cfg_valid_i,
   input  logic [7:0]          cfg_data_i,
   input  logic                cfg_last_i,
   output logic                cfg_accept_o,
   output logic                cfg_err_o,
   input  logic                inport_valid_i,
   input  logic [COEF_W-1:0]   inport_data_i,
   input  logic [5:0]          inport_idx_i,
   input  logic [ID_W-1:0]     inport_id_i,
   input  logic                inport_eob_i,
   output logic                inport_accept_o,
   output logic                outport_valid_o,
   output logic [COEF_W-1:0]   outport_data_o,
   output logic [5:0]          outport_idx_o,
   output logic [ID_W-1:0]     outport_id_o,
   output logic                outport_eob_o,
   input  logic                outport_accept_i
);

   localparam int PROD_W = COEF_W + Q_W + 1;
   localparam logic [TID_W-1:0] TID_MASK = TID_W'(NUM_TABLES - 1);

   localparam logic [5:0] ZZ_TO_RASTER [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic [1:0] {
      CFG_HDR = 2'd0,
      CFG_HI  = 2'd1,
      CFG_LO  = 2'd2
   } cfg_state_t;

   cfg_state_t        state_q, state_d;
   logic              pq16_q;
   logic [TID_W-1:0]  tq_q;
   logic [7:0]        hi_q;
   logic [5:0]        cnt_q;
   logic              cfg_err_q;
   logic              cfg_fire;
   logic              hdr_load, hi_load, tab_we, seg_err;
   logic [15:0]       entry16;

   logic [Q_W-1:0]    qtab [NUM_TABLES][64];

   logic              adv, in_fire;
   logic [TID_W-1:0]  comp_sel;

   logic              s1_valid_q;
   logic [COEF_W-1:0] s1_data_q;
   logic [5:0]        s1_idx_q;
   logic [ID_W-1:0]   s1_id_q;
   logic              s1_eob_q;
   logic [TID_W-1:0]  s1_tsel_q;

   logic              s2_valid_q;
   logic [COEF_W-1:0] s2_data_q;
   logic [5:0]        s2_idx_q;
   logic [ID_W-1:0]   s2_id_q;
   logic              s2_eob_q;

   logic [Q_W-1:0]    entry;
   logic [COEF_W-1:0] res;

   // Table writes are held off while coefficients are in flight so a table
   // never changes under a coefficient that is about to read it.
   assign cfg_accept_o    = ~s1_valid_q & ~s2_valid_q;
   assign cfg_fire        = cfg_valid_i & cfg_accept_o;
   assign adv             = ~s2_valid_q | outport_accept_i;
   assign inport_accept_o = adv & (state_q == CFG_HDR) & ~img_start_i & ~cfg_valid_i;
   assign in_fire         = inport_valid_i & inport_accept_o;
   assign entry16         = pq16_q ? {hi_q, cfg_data_i} : {8'h00, cfg_data_i};

   // Config FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= CFG_HDR;
      else         state_q <= state_d;
   end

   // Config FSM next state and per-byte actions.
   always_comb begin
      state_d  = state_q;
      hdr_load = 1'b0;
      hi_load  = 1'b0;
      tab_we   = 1'b0;
      seg_err  = 1'b0;
      if (cfg_fire) begin
         unique case (state_q)
            CFG_HDR: begin
               hdr_load = 1'b1;
               state_d  = (cfg_data_i[7:4] != 4'd0) ? CFG_HI : CFG_LO;
            end
            CFG_HI: begin
               hi_load = 1'b1;
               state_d = CFG_LO;
            end
            CFG_LO: begin
               tab_we = 1'b1;
               if (cnt_q == 6'd63) state_d = CFG_HDR;
               else                state_d = pq16_q ? CFG_HI : CFG_LO;
            end
            default: state_d = CFG_HDR;
         endcase
         if (cfg_last_i) begin
            state_d = CFG_HDR;
            seg_err = !((state_q == CFG_LO) && (cnt_q == 6'd63));
         end
      end
   end

   // Header fields, high-byte holding register, entry counter, sticky error.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pq16_q    <= 1'b0;
         tq_q      <= '0;
         hi_q      <= '0;
         cnt_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         if (hdr_load) begin
            pq16_q <= |cfg_data_i[7:4];
            tq_q   <= cfg_data_i[TID_W-1:0] & TID_MASK;
            cnt_q  <= '0;
         end
         if (hi_load) hi_q <= cfg_data_i;
         if (tab_we)  cnt_q <= cnt_q + 6'd1;
         if (img_start_i)  cfg_err_q <= 1'b0;
         else if (seg_err) cfg_err_q <= 1'b1;
      end
   end

   assign cfg_err_o = cfg_err_q;

   // Table storage; contents survive reset, writes are blocked during reset.
   always_ff @(posedge clk_i) begin
      if (tab_we && rst_ni) qtab[tq_q][cnt_q] <= entry16[Q_W-1:0];
   end

   // Table select for the component carried in the top two id bits.
   always_comb begin
      comp_sel = img_dqt_table_i[0 +: TID_W];
      unique case (inport_id_i[ID_W-1 -: 2])
         2'd1:    comp_sel = img_dqt_table_i[TID_W +: TID_W];
         2'd2:    comp_sel = img_dqt_table_i[2*TID_W +: TID_W];
         2'd3:    comp_sel = img_dqt_table_i[3*TID_W +: TID_W];
         default: comp_sel = img_dqt_table_i[0 +: TID_W];
      endcase
   end

   // Stage 1: capture the coefficient and its table address.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_idx_q   <= '0;
         s1_id_q    <= '0;
         s1_eob_q   <= 1'b0;
         s1_tsel_q  <= '0;
      end else if (img_start_i) begin
         s1_valid_q <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= in_fire;
         if (in_fire) begin
            s1_data_q <= inport_data_i;
            s1_idx_q  <= inport_idx_i;
            s1_id_q   <= inport_id_i;
            s1_eob_q  <= inport_eob_i;
            s1_tsel_q <= comp_sel & TID_MASK;
         end
      end
   end

   // Signed coefficient times unsigned entry, then wrap or saturate.
`ifdef JPEG_DQT_SAT_EN
   localparam logic signed [PROD_W-1:0] SAT_MAX = {{(Q_W+2){1'b0}}, {(COEF_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN = {{(Q_W+2){1'b1}}, {(COEF_W-1){1'b0}}};
   logic signed [PROD_W-1:0] prod;

   always_comb begin
      entry = qtab[s1_tsel_q][s1_idx_q];
      prod  = PROD_W'($signed(s1_data_q)) * PROD_W'($signed({1'b0, entry}));
      if (prod > SAT_MAX)      res = SAT_MAX[COEF_W-1:0];
      else if (prod < SAT_MIN) res = SAT_MIN[COEF_W-1:0];
      else                     res = prod[COEF_W-1:0];
   end
`else
   always_comb begin
      entry = qtab[s1_tsel_q][s1_idx_q];
      res   = COEF_W'(PROD_W'($signed(s1_data_q)) * PROD_W'($signed({1'b0, entry})));
   end
`endif

   // Stage 2: dequantised result and raster index; payload holds when idle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_idx_q   <= '0;
         s2_id_q    <= '0;
         s2_eob_q   <= 1'b0;
      end else if (img_start_i) begin
         s2_valid_q <= 1'b0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= res;
            s2_idx_q  <= ZZ_TO_RASTER[s1_idx_q];
            s2_id_q   <= s1_id_q;
            s2_eob_q  <= s1_eob_q;
         end
      end
   end

   assign outport_valid_o = s2_valid_q;
   assign outport_data_o  = s2_data_q;
   assign outport_idx_o   = s2_idx_q;
   assign outport_id_o    = s2_id_q;
   assign outport_eob_o   = s2_eob_q;

endmodule

// File: tb/tb_jpeg_dqt_pipe.sv
// Self-checking bench for jpeg_dqt_pipe: table loads, error handling,
// randomized coefficient streams against a reference model, backpressure,
// flush and the product width rule.

module tb_jpeg_dqt_pipe;

   localparam int NUM_TABLES = 4;
   localparam int COEF_W     = 16;
   localparam int Q_W        = 16;
   localparam int ID_W       = 32;
   localparam int TID_W      = 2;

   logic                clk_i;
   logic                rst_ni;
   logic                img_start_i;
   logic [4*TID_W-1:0]  img_dqt_table_i;
   logic                cfg_valid_i;
   logic [7:0]          cfg_data_i;
   logic                cfg_last_i;
   logic                cfg_accept_o;
   logic                cfg_err_o;
   logic                inport_valid_i;
   logic [COEF_W-1:0]   inport_data_i;
   logic [5:0]          inport_idx_i;
   logic [ID_W-1:0]     inport_id_i;
   logic                inport_eob_i;
   logic                inport_accept_o;
   logic                outport_valid_o;
   logic [COEF_W-1:0]   outport_data_o;
   logic [5:0]          outport_idx_o;
   logic [ID_W-1:0]     outport_id_o;
   logic                outport_eob_o;
   logic                outport_accept_i;

   jpeg_dqt_pipe #(
      .NUM_TABLES(NUM_TABLES), .COEF_W(COEF_W), .Q_W(Q_W), .ID_W(ID_W)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .img_start_i(img_start_i),
      .img_dqt_table_i(img_dqt_table_i),
      .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i), .cfg_last_i(cfg_last_i),
      .cfg_accept_o(cfg_accept_o), .cfg_err_o(cfg_err_o),
      .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i),
      .inport_idx_i(inport_idx_i), .inport_id_i(inport_id_i),
      .inport_eob_i(inport_eob_i), .inport_accept_o(inport_accept_o),
      .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o),
      .outport_idx_o(outport_idx_o), .outport_id_o(outport_id_o),
      .outport_eob_o(outport_eob_o), .outport_accept_i(outport_accept_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      int          data;
      int          idx;
      int          comp;
      logic        eob;
      logic [31:0] id;
   } coef_t;

   typedef struct {
      int          data;
      int          idx;
      logic [31:0] id;
      logic        eob;
   } exp_t;

   int    total = 0;
   int    bad   = 0;
   int    qt [4][64];
   int    zz [64];
   int    tsel_cfg [4];
   int    seg_vals [64];
   coef_t stim_q [$];
   exp_t  exp_q  [$];

   // Raster position of each zigzag index, by walking the anti-diagonals.
   function automatic void build_zigzag();
      int r = 0;
      int c = 0;
      for (int k = 0; k < 64; k++) begin
         zz[k] = r * 8 + c;
         if (((r + c) % 2) == 0) begin
            if (c == 7)      r++;
            else if (r == 0) c++;
            else begin r--; c++; end
         end else begin
            if (r == 7)      c++;
            else if (c == 0) r++;
            else begin r++; c--; end
         end
      end
   endfunction

   function automatic int model_data(int data, int idx, int comp);
      longint e;
      longint p;
      e = longint'(qt[tsel_cfg[comp] % NUM_TABLES][idx]);
      p = longint'(data) * e;
`ifdef JPEG_DQT_SAT_EN
      if (p > 32767)       p = 32767;
      else if (p < -32768) p = -32768;
`else
      p = p & 64'hFFFF;
      if (p >= 32768) p = p - 65536;
`endif
      return int'(p);
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_tables(input int t0, input int t1, input int t2, input int t3);
      tsel_cfg[0] = t0; tsel_cfg[1] = t1; tsel_cfg[2] = t2; tsel_cfg[3] = t3;
      img_dqt_table_i = {2'(t3), 2'(t2), 2'(t1), 2'(t0)};
   endtask

   task automatic send_cfg(input int b, input logic last);
      int waited = 0;
      cfg_valid_i = 1'b1;
      cfg_data_i  = 8'(b);
      cfg_last_i  = last;
      @(negedge clk_i);
      while (!cfg_accept_o && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      if (!cfg_accept_o) begin
         total++; bad++;
         $display("FAIL cfg_accept_timeout got accept=%b want 1 within 50 cycles", cfg_accept_o);
      end
      tick();
      cfg_valid_i = 1'b0;
      cfg_last_i  = 1'b0;
   endtask

   // Header byte, then n entries from seg_vals; last flagged on the final byte.
   task automatic send_segment(input int hdr, input logic is16, input int n, input logic last);
      send_cfg(hdr, 1'b0);
      for (int k = 0; k < n; k++) begin
         if (is16) send_cfg((seg_vals[k] >> 8) & 8'hFF, 1'b0);
         send_cfg(seg_vals[k] & 8'hFF, last && (k == n - 1));
      end
   endtask

   task automatic queue_probe(input int comp);
      coef_t c;
      for (int k = 0; k < 64; k++) begin
         c.data = 1; c.idx = k; c.comp = comp; c.eob = (k == 63);
         c.id   = {2'(comp), 30'(k * 7 + 1)};
         stim_q.push_back(c);
      end
   endtask

   task automatic queue_random(input int n);
      coef_t c;
      for (int k = 0; k < n; k++) begin
         c.data = int'($urandom_range(0, 65535)) - 32768;
         c.idx  = int'($urandom_range(0, 63));
         c.comp = int'($urandom_range(0, 3));
         c.eob  = ((k % 8) == 7);
         c.id   = {2'(c.comp), 30'($urandom)};
         stim_q.push_back(c);
      end
   endtask

   // Drives stim_q, scoreboards every output transfer and checks that a
   // stalled output holds. mode 0: always accept; mode 1: accept 1,0,0,1.
   task automatic run_stream(input int mode, input int max_cycles, output int cycles);
      int          si = 0;
      int          cyc = 0;
      logic        held_v = 1'b0;
      logic [15:0] hd;
      logic [5:0]  hix;
      coef_t       c;
      exp_t        e;
      while ((si < stim_q.size() || exp_q.size() > 0 || outport_valid_o) && cyc < max_cycles) begin
         if (si < stim_q.size()) begin
            c = stim_q[si];
            inport_valid_i = 1'b1;
            inport_data_i  = COEF_W'(c.data);
            inport_idx_i   = 6'(c.idx);
            inport_id_i    = c.id;
            inport_eob_i   = c.eob;
         end else begin
            inport_valid_i = 1'b0;
         end
         outport_accept_i = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
         @(negedge clk_i);
         if (outport_valid_o) begin
            if (held_v) begin
               total++;
               if (outport_data_o !== hd || outport_idx_o !== hix) begin
                  bad++;
                  $display("FAIL stall_hold got d=%h i=%0d want d=%h i=%0d", outport_data_o, outport_idx_o, hd, hix);
               end
            end
            if (outport_accept_i) begin
               total++;
               held_v = 1'b0;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL stream_extra got d=%0d i=%0d want no output", $signed(outport_data_o), outport_idx_o);
               end else begin
                  e = exp_q.pop_front();
                  if (int'($signed(outport_data_o)) !== e.data || int'(outport_idx_o) !== e.idx ||
                      outport_id_o !== e.id || outport_eob_o !== e.eob) begin
                     bad++;
                     $display("FAIL stream_out got d=%0d i=%0d id=%h eob=%b want d=%0d i=%0d id=%h eob=%b",
                              $signed(outport_data_o), outport_idx_o, outport_id_o, outport_eob_o,
                              e.data, e.idx, e.id, e.eob);
                  end
               end
            end else begin
               held_v = 1'b1;
               hd     = outport_data_o;
               hix    = outport_idx_o;
            end
         end
         if (inport_valid_i && inport_accept_o) begin
            e.data = model_data(c.data, c.idx, c.comp);
            e.idx  = zz[c.idx];
            e.id   = c.id;
            e.eob  = c.eob;
            exp_q.push_back(e);
            si++;
         end
         tick();
         cyc++;
      end
      inport_valid_i = 1'b0;
      if (cyc >= max_cycles) begin
         total++; bad++;
         $display("FAIL stream_timeout got sent=%0d pending=%0d want all done within %0d cycles", si, exp_q.size(), max_cycles);
      end
      stim_q.delete();
      exp_q.delete();
      cycles = cyc;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      total++;
      if (outport_valid_o !== 1'b0 || outport_data_o !== '0 || outport_idx_o !== '0 ||
          outport_id_o !== '0 || outport_eob_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got v=%b d=%h i=%h id=%h eob=%b want all 0",
                  outport_valid_o, outport_data_o, outport_idx_o, outport_id_o, outport_eob_o);
      end
      total++;
      if (cfg_err_o !== 1'b0) begin
         bad++; $display("FAIL reset_cfg_err got %b want 0", cfg_err_o);
      end
      tick();
      rst_ni = 1'b1;
      @(negedge clk_i);
      total++;
      if (cfg_accept_o !== 1'b1 || inport_accept_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle_accepts got cfg=%b in=%b want 1 1", cfg_accept_o, inport_accept_o);
      end
      tick();
   endtask

   task automatic test_load8_basic();
      for (int k = 0; k < 64; k++) begin seg_vals[k] = k + 1; qt[1][k] = k + 1; end
      send_segment(8'h01, 1'b0, 64, 1'b1);
      set_tables(1, 0, 0, 0);
      total++;
      if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL load8_err got %b want 0", cfg_err_o); end
      outport_accept_i = 1'b1;
      inport_valid_i = 1'b1; inport_data_i = 16'd3; inport_idx_i = 6'd5;
      inport_id_i = 32'h0000_0123; inport_eob_i = 1'b1;
      @(negedge clk_i);
      total++;
      if (inport_accept_o !== 1'b1) begin bad++; $display("FAIL basic_accept got %b want 1", inport_accept_o); end
      tick();
      inport_valid_i = 1'b0;
      @(negedge clk_i);
      total++;
      if (outport_valid_o !== 1'b0) begin bad++; $display("FAIL basic_latency1 got v=%b want 0", outport_valid_o); end
      @(negedge clk_i);
      total++;
      if (outport_valid_o !== 1'b1 || outport_data_o !== 16'd18 || outport_idx_o !== 6'd2 ||
          outport_id_o !== 32'h0000_0123 || outport_eob_o !== 1'b1) begin
         bad++;
         $display("FAIL basic_result got v=%b d=%0d i=%0d id=%h eob=%b want v=1 d=18 i=2 id=00000123 eob=1",
                  outport_valid_o, outport_data_o, outport_idx_o, outport_id_o, outport_eob_o);
      end
      tick();
   endtask

   task automatic test_multi16();
      int cyc;
      send_cfg(8'h10, 1'b0);
      for (int k = 0; k < 64; k++) begin send_cfg(8'h01, 1'b0); send_cfg(8'h02, 1'b0); qt[0][k] = 258; end
      send_cfg(8'h12, 1'b0);
      for (int k = 0; k < 64; k++) begin send_cfg(8'h00, 1'b0); send_cfg(8'h03, k == 63); qt[2][k] = 3; end
      total++;
      if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL multi16_err got %b want 0", cfg_err_o); end
      set_tables(0, 2, 0, 0);
      queue_probe(0);
      queue_probe(1);
      run_stream(0, 500, cyc);
   endtask

   task automatic test_truncation();
      int cyc;
      for (int k = 0; k < 64; k++) begin seg_vals[k] = k + 50; qt[3][k] = k + 50; end
      send_segment(8'h03, 1'b0, 64, 1'b1);
      for (int k = 0; k < 10; k++) begin seg_vals[k] = 7; qt[3][k] = 7; end
      send_segment(8'h03, 1'b0, 10, 1'b1);
      total++;
      if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL trunc_err got %b want 1", cfg_err_o); end
      set_tables(3, 0, 0, 0);
      queue_probe(0);
      run_stream(0, 300, cyc);
      img_start_i = 1'b1;
      tick();
      img_start_i = 1'b0;
      @(negedge clk_i);
      total++;
      if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL trunc_err_clear got %b want 0", cfg_err_o); end
      tick();
      send_cfg(8'h01, 1'b1);
      @(negedge clk_i);
      total++;
      if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL hdr_last_err got %b want 1", cfg_err_o); end
      tick();
      img_start_i = 1'b1;
      tick();
      img_start_i = 1'b0;
   endtask

   task automatic test_reset_mid_segment();
      int cyc;
      send_cfg(8'h01, 1'b0);
      for (int k = 0; k < 5; k++) begin send_cfg(8'h55, 1'b0); qt[1][k] = 8'h55; end
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      set_tables(0, 0, 1, 0);
      queue_probe(2);
      run_stream(0, 300, cyc);
   endtask

   task automatic test_back_to_back();
      int cyc;
      set_tables(2, 3, 0, 1);
      queue_random(64);
      run_stream(0, 500, cyc);
      total++;
      if (cyc !== 66) begin bad++; $display("FAIL back_to_back_cycles got %0d want 66", cyc); end
   endtask

   task automatic test_backpressure();
      int cyc;
      set_tables(3, 2, 1, 0);
      queue_random(64);
      run_stream(1, 1000, cyc);
   endtask

   task automatic test_saturation();
      int n;
      int want;
      for (int k = 0; k < 64; k++) begin seg_vals[k] = 100; qt[1][k] = 100; end
      send_segment(8'h01, 1'b0, 64, 1'b1);
      set_tables(1, 0, 0, 0);
      outport_accept_i = 1'b1;
      for (int t = 0; t < 2; t++) begin
`ifdef JPEG_DQT_SAT_EN
         want = (t == 0) ? 32767 : -32768;
`else
         want = (t == 0) ? -31072 : 31072;
`endif
         inport_valid_i = 1'b1;
         inport_data_i  = (t == 0) ? 16'd1000 : 16'hFC18;
         inport_idx_i   = 6'd10;
         inport_id_i    = 32'h0000_00A0;
         inport_eob_i   = 1'b0;
         @(negedge clk_i);
         tick();
         inport_valid_i = 1'b0;
         n = 0;
         @(negedge clk_i);
         while (!outport_valid_o && n < 10) begin @(negedge clk_i); n++; end
         total++;
         if (outport_valid_o !== 1'b1 || int'($signed(outport_data_o)) !== want || int'(outport_idx_o) !== zz[10]) begin
            bad++;
            $display("FAIL sat_result got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                     outport_valid_o, $signed(outport_data_o), outport_idx_o, want, zz[10]);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      outport_accept_i = 1'b0;
      inport_valid_i = 1'b1; inport_data_i = 16'd5; inport_idx_i = 6'd1;
      inport_id_i = 32'h1; inport_eob_i = 1'b0;
      tick();
      inport_data_i = 16'd6; inport_idx_i = 6'd2; inport_id_i = 32'h2;
      tick();
      inport_valid_i = 1'b0;
      @(negedge clk_i);
      total++;
      if (outport_valid_o !== 1'b1) begin bad++; $display("FAIL flush_setup got v=%b want 1", outport_valid_o); end
      img_start_i = 1'b1;
      tick();
      img_start_i = 1'b0;
      @(negedge clk_i);
      total++;
      if (outport_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", outport_valid_o); end
      outport_accept_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         if (outport_valid_o) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL flush_stale got %0d outputs want 0", seen); end
      tick();
   endtask

   initial begin
      rst_ni = 1'b0; img_start_i = 1'b0; img_dqt_table_i = '0;
      cfg_valid_i = 1'b0; cfg_data_i = '0; cfg_last_i = 1'b0;
      inport_valid_i = 1'b0; inport_data_i = '0; inport_idx_i = '0;
      inport_id_i = '0; inport_eob_i = 1'b0; outport_accept_i = 1'b1;
      for (int t = 0; t < 4; t++) tsel_cfg[t] = 0;
      build_zigzag();
      test_reset();
      test_load8_basic();
      test_multi16();
      test_truncation();
      test_reset_mid_segment();
      test_back_to_back();
      test_backpressure();
      test_saturation();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
